instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv32_starter_pkg.sv | 25 ++
 rtl/instr_fetch_queue.sv | 43 ++++
 rtl/instr_fetch.sv | 85 ++++++++
 tb/tb_instr_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv32_starter_pkg.sv
// riscv32_starter: shared types for the starter core (opcodes, formats, fetch FSM states, fetch queue entry)
package riscv32_starter;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_t;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} format_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue.sv
// fetch_queue: 2-entry instruction FIFO with registered head
//   push/din  write an entry at the tail
//   pop       consume the head (ignored while empty)
//   flush     empty the queue (wins over push/pop)
//   head      registered oldest entry, count = number of valid entries
module fetch_queue
    import riscv32_starter::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t tail;
    logic         do_pop;

    assign do_pop = pop && count != 2'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            // with one entry, a simultaneous pop+push bypasses straight into head
            if (do_pop)
                head <= (push && count == 2'd1) ? din : tail;
            else if (push && count == 2'd0)
                head <= din;
            if (push && (count == 2'd2 || (count == 2'd1 && !do_pop)))
                tail <= din;
            count <= count + {1'b0, push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit feeding a 2-entry queue
//   clk, reset                     clock, async active-high reset
//   imem_req/addr/gnt/rvalid/rdata instruction memory request/response
//   redirect, redirect_pc          flush and refetch from a new address
//   instr_valid/instr/instr_pc     head of the queue towards decode
//   instr_ready                    decode consumes the head
module instr_fetch
    import riscv32_starter::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam logic [1:0] QMAX = 2'(QDEPTH);

    fetch_state_t state, state_n;
    logic [31:0]  fetch_pc, req_pc;
    logic [1:0]   count;
    logic         grant, push, pop;
    fetch_entry_t din, head;

    // only REQ has no request in flight, so the credit check reduces to count < QMAX there
    assign imem_req    = state == REQ && count < QMAX;
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req && imem_gnt;
    assign push        = state == WAIT && imem_rvalid && !redirect;
    assign pop         = instr_ready && !redirect;
    assign din         = '{pc: req_pc, instr: imem_rdata};
    assign instr_valid = count != 2'd0;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = REQ;
            REQ:     state_n = grant ? (redirect ? DROP : WAIT) : REQ;
            WAIT:    state_n = imem_rvalid ? REQ : (redirect ? DROP : WAIT);
            DROP:    state_n = imem_rvalid ? REQ : DROP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_n;
            if (redirect)
                fetch_pc <= redirect_pc & ~32'h3;
            else if (grant)
                fetch_pc <= fetch_pc + 32'd4;
            if (grant)
                req_pc <= fetch_pc;
        end
    end

    fetch_queue u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table plus randomized scoreboard run for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    typedef struct {
        logic        gnt, rv, rdy, redir;
        logic [31:0] rpc, dpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[24];

    function automatic logic [31:0] w(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic gnt, rv, rdy, redir, input logic [31:0] rpc, dpc,
                                input logic ereq, input logic [31:0] eaddr, input logic ev,
                                input logic [31:0] epc);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.dpc = dpc;
        v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_row(input int i);
        vec_t v = vecs[i];
        imem_gnt    = v.gnt;
        imem_rvalid = v.rv;
        imem_rdata  = v.rv ? w(v.dpc) : 32'hDEAD_BEEF;
        instr_ready = v.rdy;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        #1;
        chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(v.ereq));
        chk($sformatf("row%0d_addr", i), imem_addr, v.eaddr);
        chk($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(v.ev));
        if (v.ev) begin
            chk($sformatf("row%0d_pc", i), instr_pc, v.epc);
            chk($sformatf("row%0d_instr", i), instr, w(v.epc));
        end
    endtask

    task automatic idle_inputs();
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        instr_ready = 0; redirect = 0; redirect_pc = '0;
    endtask

    initial begin
        int          out, dly, deliveries;
        logic [31:0] oaddr, exp_req, exp_del, tgt;
        logic        after_redir, new_gnt;

        //            gnt rv rdy rd rpc            dpc            req addr           v  pc
        vecs[0]  = mk(1, 0, 0, 0, 0,             0,             0, 32'h0,         0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0,             0,             1, 32'h0,         0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0,             32'h0,         0, 32'h4,         0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0,             0,             1, 32'h4,         1, 32'h0);
        vecs[4]  = mk(1, 1, 0, 0, 0,             32'h4,         0, 32'h8,         1, 32'h0);
        vecs[5]  = mk(1, 0, 0, 0, 0,             0,             0, 32'h8,         1, 32'h0);
        vecs[6]  = mk(1, 0, 1, 0, 0,             0,             0, 32'h8,         1, 32'h0);
        vecs[7]  = mk(1, 0, 1, 0, 0,             0,             1, 32'h8,         1, 32'h4);
        vecs[8]  = mk(1, 1, 1, 0, 0,             32'h8,         0, 32'hC,         0, 0);
        vecs[9]  = mk(1, 0, 1, 0, 0,             0,             1, 32'hC,         1, 32'h8);
        vecs[10] = mk(0, 0, 1, 1, 32'h103,       0,             0, 32'h10,        0, 0);
        vecs[11] = mk(0, 1, 1, 0, 0,             32'hC,         0, 32'h100,       0, 0);
        vecs[12] = mk(1, 0, 1, 0, 0,             0,             1, 32'h100,       0, 0);
        vecs[13] = mk(1, 1, 1, 0, 0,             32'h100,       0, 32'h104,       0, 0);
        vecs[14] = mk(1, 0, 1, 1, 32'h200,       0,             1, 32'h104,       1, 32'h100);
        vecs[15] = mk(0, 0, 1, 0, 0,             0,             0, 32'h200,       0, 0);
        vecs[16] = mk(0, 1, 1, 0, 0,             32'h104,       0, 32'h200,       0, 0);
        vecs[17] = mk(1, 0, 1, 0, 0,             0,             1, 32'h200,       0, 0);
        vecs[18] = mk(1, 1, 1, 0, 0,             32'h200,       0, 32'h204,       0, 0);
        vecs[19] = mk(0, 0, 0, 1, 32'hFFFF_FFFF, 0,             1, 32'h204,       1, 32'h200);
        vecs[20] = mk(1, 0, 0, 0, 0,             0,             1, 32'hFFFF_FFFC, 0, 0);
        vecs[21] = mk(1, 1, 0, 0, 0,             32'hFFFF_FFFC, 0, 32'h0,         0, 0);
        vecs[22] = mk(1, 0, 0, 0, 0,             0,             1, 32'h0,         1, 32'hFFFF_FFFC);
        vecs[23] = mk(1, 1, 0, 0, 0,             32'h0,         0, 32'h4,         1, 32'hFFFF_FFFC);

        #1;
        chk("reset_req", 32'(imem_req), 0);
        chk("reset_addr", imem_addr, 0);
        chk("reset_valid", 32'(instr_valid), 0);
        chk("reset_instr", instr, 0);
        chk("reset_pc", instr_pc, 0);

        repeat (2) @(negedge clk);
        reset = 0;
        for (int i = 0; i < 23; i++) begin
            apply_row(i);
            @(negedge clk);
        end

        // reset asserted mid-cycle while a fetch is outstanding and the queue holds data
        apply_row(23);
        #2 reset = 1;
        #1;
        chk("midreset_req", 32'(imem_req), 0);
        chk("midreset_addr", imem_addr, 0);
        chk("midreset_valid", 32'(instr_valid), 0);
        chk("midreset_instr", instr, 0);
        chk("midreset_pc", instr_pc, 0);
        idle_inputs();
        @(negedge clk);
        reset = 0;
        #1;
        chk("restart_idle_req", 32'(imem_req), 0);
        @(negedge clk);
        #1;
        chk("restart_req", 32'(imem_req), 1);
        chk("restart_addr", imem_addr, 0);

        // randomized run against a fetch-stream scoreboard
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        out = 0; dly = 0; deliveries = 0; oaddr = '0;
        exp_req = '0; exp_del = '0; after_redir = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            imem_rvalid = 0;
            imem_rdata  = $urandom;
            if (out != 0 && dly == 0) begin
                imem_rvalid = 1;
                imem_rdata  = w(oaddr);
            end
            imem_gnt    = $urandom_range(0, 3) != 0;
            instr_ready = $urandom_range(0, 3) != 0;
            redirect    = $urandom_range(0, 19) == 0;
            redirect_pc = $urandom_range(0, 1) != 0 ? $urandom : 32'hFFFF_FFF0 + $urandom_range(0, 15);
            #1;
            if (after_redir)
                chk("rnd_valid_after_redirect", 32'(instr_valid), 0);
            if (instr_valid && instr_ready && !redirect) begin
                chk("rnd_pc", instr_pc, exp_del);
                chk("rnd_instr", instr, w(exp_del));
                exp_del += 4;
                deliveries++;
            end
            if (imem_req)
                chk("rnd_single_outstanding", out, 0);
            new_gnt = imem_req && imem_gnt;
            if (new_gnt)
                chk("rnd_req_addr", imem_addr, exp_req);
            if (imem_rvalid)
                out = 0;
            else if (out != 0)
                dly--;
            if (new_gnt) begin
                out = 1;
                oaddr = imem_addr;
                dly = $urandom_range(0, 2);
                exp_req += 4;
            end
            after_redir = redirect;
            if (redirect) begin
                tgt = {redirect_pc[31:2], 2'b00};
                exp_req = tgt;
                exp_del = tgt;
            end
            @(negedge clk);
        end
        chk("rnd_progress", 32'(deliveries > 300), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
